link_tx_scheduler: RTL and testbench
====================================

# link_tx_scheduler

Transmit-side controller for the inter-FPGA player link. It collects the local player's location and discrete game events and arbitrates between them, event first. It builds 89-bit frames and drives them MSB-first over the three-wire serial link (data, clock, active-low select) that the opponent FPGA's receiver samples. It sits beside the receive-side syncer in the pixel-clock domain and is the only driver of the outgoing link pins.

## Interface
- HALF_PERIOD, 50: pixel-clock cycles per half link-clock period; ≥2.
- GUARD_CYCLES, 4: cycles `sel_out` is held low before the first bit, and high after the last bit.
- HEARTBEAT_CYCLES, 742500: idle cycles before a heartbeat frame is sent (only with the macro).

Ports:
- clk_pixel_in  in  1  pixel clock; the only clock.
- rst_in  in  1  synchronous, active-high reset.
- location_in  in  63  local player location (location_t).
- location_in_valid  in  1  one-cycle strobe; `location_in` is latched.
- event_in  in  21  event payload.
- event_valid_in  in  1  event request.
- event_ready_out  out  1  event buffer is free; a transfer occurs when valid && ready.
- data_out  out  1  serial data, MSB first.
- data_clk_out  out  1  link clock; the receiver samples on the rising edge.
- sel_out  out  1  frame select, active low.
- busy_out  out  1  high from frame start through the end of the trailing guard.
- frame_done_out  out  1  one-cycle pulse on the last trailing-guard cycle.

## Operation
- Frame layout: [88:86] = 3'b101 sync; [85:23] = location register; [22:21] = type (00 location, 01 event, 10 heartbeat); [20:0] = aux (event payload, or 0).
- Location register: updated on every `location_in_valid`, including mid-frame, and sets `loc_dirty`.
- Event buffer: one entry. `event_ready_out` = !event_pending.
- States: IDLE → SETUP → SHIFT → HOLD → IDLE.
- Start decision in IDLE, in priority order:
  - `event_pending`: send an event frame; clears both `event_pending` and `loc_dirty`.
  - `loc_dirty`: send a location frame; clears `loc_dirty`.
  - Heartbeat expired: send a heartbeat frame.
  - None of these: stay in IDLE.
- On start, the 89-bit shift register loads from the register values as they were before that edge.
- Simultaneous events at start:
  - A `location_in_valid` in the start cycle updates the register, and the set of `loc_dirty` wins over the clear. The next frame carries the new value.
  - An event accepted in the start cycle is not seen by that decision; it becomes pending for the next frame.
- SETUP:
  - `sel_out` = 0, `data_clk_out` = 0, `data_out` = bit 88.
  - Lasts GUARD_CYCLES.
- SHIFT: for each bit k = 88..0:
  - `data_clk_out` is low for HALF_PERIOD cycles, then high for HALF_PERIOD cycles.
  - `data_out` changes only on the cycle `data_clk_out` falls, or on SHIFT entry.
  - The bit counter covers 0..88; no wrap.
- HOLD:
  - `sel_out` = 1, `data_clk_out` = 0.
  - Lasts GUARD_CYCLES; `frame_done_out` pulses on its last cycle.
- Reset, including mid-frame: on the next cycle the state is IDLE, `sel_out` = 1, and `data_clk_out`, `data_out`, `busy_out` and `frame_done_out` are 0. The location register, `loc_dirty`, `event_pending` and the heartbeat counter are cleared, and `event_ready_out` = 1. A partial frame is abandoned; no `frame_done_out` is produced for it.

## Timing
- Start latency: `busy_out` and `sel_out` = 0 on the cycle after the start decision.
- Frame length: 2·GUARD_CYCLES + 89·2·HALF_PERIOD cycles. With HALF_PERIOD = 4 and GUARD_CYCLES = 2 this is 716 cycles.
- Back-to-back frames: the earliest next start is the cycle after `frame_done_out`. This gives a minimum of one IDLE cycle, with `sel_out` high throughout HOLD.
- Event handshake: `event_ready_out` falls the cycle after acceptance and rises the cycle after the event frame loads.
- Location updates arriving faster than frames are coalesced; the latest value wins.

## Configuration
- LINK_HEARTBEAT_EN defined:
  - An idle counter increments every IDLE cycle with nothing pending, and resets on any frame start and on reset.
  - When the counter reaches HEARTBEAT_CYCLES, a type-10 frame is sent carrying the current location register and aux 0.
- LINK_HEARTBEAT_EN undefined:
  - No counter exists; type 10 is never emitted and the link stays silent while idle.

## Test plan
Bench parameters: HALF_PERIOD = 4, GUARD_CYCLES = 2, HEARTBEAT_CYCLES = 2000.
- Location frame: strobe location 63'h7A5A_5A5A_5A5A_5A5A → one frame is sent; sampling `data_out` on `data_clk_out` rises gives 3'b101, that location, type 00, aux 0. `frame_done_out` pulses 716 cycles after `sel_out` falls.
- Event priority: during a frame, strobe location L2 and send event 21'h155555 → the next frame is type 01 with aux 21'h155555 and location L2, and no separate location frame follows. `event_ready_out` is low from acceptance until the event frame loads.
- Coalescing at the start edge: strobe L1 and L2 mid-frame, then L3 on the next start cycle → the next frame carries L2, and the frame after it carries L3.
- Mid-frame reset: assert `rst_in` at bit 40 → the next cycle shows `sel_out` = 1, `busy_out` = 0, `event_ready_out` = 1, with no `frame_done_out` and no further frames.
- Heartbeat (macro on): after one location frame, hold inputs idle → a type-10 frame starts 2000 IDLE cycles after `frame_done_out` and repeats thereafter. With the macro off, `sel_out` stays 1 for 10000 cycles.
- Bit timing: in every SHIFT phase, `data_out` never toggles while `data_clk_out` is high, and `sel_out` stays low across all 89 rising edges.

Source files
------------

// File: rtl/link_tx_scheduler.sv
// Transmit-side scheduler for the inter-FPGA player link: arbitrates event/location
// (and optionally heartbeat, enabled by LINK_HEARTBEAT_EN) frames and shifts them out MSB-first.
module link_tx_scheduler #(
    parameter int HALF_PERIOD      = 50,
    parameter int GUARD_CYCLES     = 4,
    parameter int HEARTBEAT_CYCLES = 742500
) (
    input  logic        clk_pixel_in,
    input  logic        rst_in,
    input  logic [62:0] location_in,
    input  logic        location_in_valid,
    input  logic [20:0] event_in,
    input  logic        event_valid_in,
    output logic        event_ready_out,
    output logic        data_out,
    output logic        data_clk_out,
    output logic        sel_out,
    output logic        busy_out,
    output logic        frame_done_out
);

    localparam int CNT_MAX = (HALF_PERIOD > GUARD_CYCLES) ? HALF_PERIOD : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [2:0] SYNC_WORD = 3'b101;
    localparam logic [1:0] TYPE_LOC  = 2'b00;
    localparam logic [1:0] TYPE_EVT  = 2'b01;
    localparam logic [1:0] TYPE_HB   = 2'b10;
    localparam logic [6:0] LAST_BIT  = 7'd88;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       bit_cnt_q, bit_cnt_d;
    logic             clk_hi_q, clk_hi_d;
    logic [88:0]      shreg_q, shreg_d;
    logic [62:0]      loc_q, loc_d;
    logic             loc_dirty_q, loc_dirty_d;
    logic [20:0]      evt_q, evt_d;
    logic             evt_pending_q, evt_pending_d;

    logic hb_expired;
    logic start_evt, start_loc, start_hb, start_any;

`ifdef LINK_HEARTBEAT_EN
    localparam int HB_W = $clog2(HEARTBEAT_CYCLES + 1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);
    localparam logic [HB_W-1:0] HB_ONE  = HB_W'(1);

    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;

    // Expires on the IDLE cycle that would bring the count to HEARTBEAT_CYCLES.
    assign hb_expired = (hb_cnt_q == HB_LAST);

    always_comb begin
        hb_cnt_d = hb_cnt_q;
        if (start_any) begin
            hb_cnt_d = '0;
        end else if (state_q == ST_IDLE) begin
            hb_cnt_d = hb_cnt_q + HB_ONE;
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            hb_cnt_q <= '0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
        end
    end
`else
    // Heartbeat disabled in this build: the condition is constant false for any valid setting.
    assign hb_expired = (HEARTBEAT_CYCLES < 0);
`endif

    assign start_evt = (state_q == ST_IDLE) && evt_pending_q;
    assign start_loc = (state_q == ST_IDLE) && !evt_pending_q && loc_dirty_q;
    assign start_hb  = (state_q == ST_IDLE) && !evt_pending_q && !loc_dirty_q && hb_expired;
    assign start_any = start_evt || start_loc || start_hb;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        clk_hi_d      = clk_hi_q;
        shreg_d       = shreg_q;
        loc_d         = loc_q;
        loc_dirty_d   = loc_dirty_q;
        evt_d         = evt_q;
        evt_pending_d = evt_pending_q;

        case (state_q)
            ST_IDLE: begin
                if (start_any) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    if (start_evt) begin
                        shreg_d = {SYNC_WORD, loc_q, TYPE_EVT, evt_q};
                    end else if (start_loc) begin
                        shreg_d = {SYNC_WORD, loc_q, TYPE_LOC, 21'd0};
                    end else begin
                        shreg_d = {SYNC_WORD, loc_q, TYPE_HB, 21'd0};
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d   = ST_SHIFT;
                    cnt_d     = '0;
                    bit_cnt_d = LAST_BIT;
                    clk_hi_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != HALF_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = '0;
                    if (!clk_hi_q) begin
                        clk_hi_d = 1'b1;
                    end else begin
                        // Falling edge of the link clock: advance to the next bit.
                        clk_hi_d = 1'b0;
                        if (bit_cnt_q == 7'd0) begin
                            state_d = ST_HOLD;
                        end else begin
                            shreg_d   = {shreg_q[87:0], 1'b0};
                            bit_cnt_d = bit_cnt_q - 7'd1;
                        end
                    end
                end
            end
            default: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase

        // Clear before set so a same-cycle update survives the start decision.
        if (start_evt || start_loc) begin
            loc_dirty_d = 1'b0;
        end
        if (location_in_valid) begin
            loc_d       = location_in;
            loc_dirty_d = 1'b1;
        end

        if (start_evt) begin
            evt_pending_d = 1'b0;
        end
        if (event_valid_in && !evt_pending_q) begin
            evt_d         = event_in;
            evt_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_cnt_q     <= '0;
            clk_hi_q      <= 1'b0;
            shreg_q       <= '0;
            loc_q         <= '0;
            loc_dirty_q   <= 1'b0;
            evt_q         <= '0;
            evt_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            clk_hi_q      <= clk_hi_d;
            shreg_q       <= shreg_d;
            loc_q         <= loc_d;
            loc_dirty_q   <= loc_dirty_d;
            evt_q         <= evt_d;
            evt_pending_q <= evt_pending_d;
        end
    end

    assign event_ready_out = !evt_pending_q;
    assign sel_out         = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign busy_out        = (state_q != ST_IDLE);
    assign data_clk_out    = clk_hi_q;
    assign data_out        = ((state_q == ST_SETUP) || (state_q == ST_SHIFT)) && shreg_q[88];
    assign frame_done_out  = (state_q == ST_HOLD) && (cnt_q == GUARD_LAST);

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Scoreboard bench for link_tx_scheduler: expected frames are queued at stimulus time
// and compared against the bits sampled on each rising link clock.
module tb_link_tx_scheduler;

    localparam int HP        = 4;
    localparam int GC        = 2;
    localparam int HB        = 2000;
    localparam int FRAME_LEN = 2 * GC + 89 * 2 * HP;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [62:0] location_in;
    logic        location_in_valid;
    logic [20:0] event_in;
    logic        event_valid_in;
    logic        event_ready_out;
    logic        data_out;
    logic        data_clk_out;
    logic        sel_out;
    logic        busy_out;
    logic        frame_done_out;

    always #5 clk = ~clk;

    link_tx_scheduler #(
        .HALF_PERIOD(HP),
        .GUARD_CYCLES(GC),
        .HEARTBEAT_CYCLES(HB)
    ) dut (
        .clk_pixel_in(clk),
        .rst_in(rst_in),
        .location_in(location_in),
        .location_in_valid(location_in_valid),
        .event_in(event_in),
        .event_valid_in(event_valid_in),
        .event_ready_out(event_ready_out),
        .data_out(data_out),
        .data_clk_out(data_clk_out),
        .sel_out(sel_out),
        .busy_out(busy_out),
        .frame_done_out(frame_done_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [88:0] mk_frame(input logic [62:0] loc, input logic [1:0] typ,
                                             input logic [20:0] aux);
        return {3'b101, loc, typ, aux};
    endfunction

    logic [88:0] exp_q[$];

    // Monitor: collects bits on rising link clock and scores each completed frame.
    logic [88:0] mon_shift;
    int          mon_bits;
    int          mon_busy_len;
    int          mon_viol;
    logic        prev_clk;
    logic        prev_data;
    int          frames_seen;

    initial begin
        mon_shift    = '0;
        mon_bits     = 0;
        mon_busy_len = 0;
        mon_viol     = 0;
        prev_clk     = 1'b0;
        prev_data    = 1'b0;
        frames_seen  = 0;
    end

    always @(negedge clk) begin
        logic [88:0] exp_frame;
        if (rst_in || !busy_out) begin
            mon_shift    = '0;
            mon_bits     = 0;
            mon_busy_len = 0;
            mon_viol     = 0;
        end else begin
            mon_busy_len++;
            if (data_clk_out && !prev_clk) begin
                mon_shift = {mon_shift[87:0], data_out};
                mon_bits++;
                if (sel_out) mon_viol++;
            end
            if (data_clk_out && prev_clk && (data_out !== prev_data)) mon_viol++;
            if (frame_done_out) begin
                frames_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 128'(mon_shift), 128'd0);
                end else begin
                    exp_frame = exp_q.pop_front();
                    check("frame_bits", 128'(mon_shift), 128'(exp_frame));
                    check("bit_count", 128'(mon_bits), 128'd89);
                    check("frame_len", 128'(mon_busy_len), 128'(FRAME_LEN));
                    check("bit_timing", 128'(mon_viol), 128'd0);
                end
                $display("frame %0d: sync %b loc %h type %b aux %h", frames_seen,
                         mon_shift[88:86], mon_shift[85:23], mon_shift[22:21], mon_shift[20:0]);
            end
        end
        prev_clk  = data_clk_out;
        prev_data = data_out;
    end

    task automatic strobe_loc(input logic [62:0] loc);
        location_in       = loc;
        location_in_valid = 1'b1;
        @(negedge clk);
        location_in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_done_out) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({"timeout_", tag}, 128'd0, 128'd1);
    endtask

    task automatic wait_busy(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy_out) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({"timeout_", tag}, 128'd0, 128'd1);
    endtask

    localparam logic [62:0] LA = 63'h7A5A_5A5A_5A5A_5A5A;
    localparam logic [62:0] L1 = 63'h1234_5678_9ABC_DEF0;
    localparam logic [62:0] L2 = 63'h2F0F_0F0F_F0F0_1234;
    localparam logic [62:0] L3 = 63'h5555_AAAA_3333_CCCC;
    localparam logic [62:0] LR = 63'h0000_FFFF_0000_FFFF;
    localparam logic [62:0] LH = 63'h6C6C_1111_2222_3333;
    localparam logic [20:0] EV = 21'h155555;

    initial begin
        int cnt;
        rst_in            = 1'b1;
        location_in       = '0;
        location_in_valid = 1'b0;
        event_in          = '0;
        event_valid_in    = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_sel", 128'(sel_out), 128'd1);
        check("rst_busy", 128'(busy_out), 128'd0);
        check("rst_dclk", 128'(data_clk_out), 128'd0);
        check("rst_data", 128'(data_out), 128'd0);
        check("rst_done", 128'(frame_done_out), 128'd0);
        check("rst_ready", 128'(event_ready_out), 128'd1);
        rst_in = 1'b0;
        @(negedge clk);

        // Plain location frame
        exp_q.push_back(mk_frame(LA, 2'b00, 21'd0));
        strobe_loc(LA);
        wait_done("loc_frame", 2000);
        @(negedge clk);
        check("idle_after_done", 128'(busy_out), 128'd0);

        // Event priority over a location update arriving in the same frame
        exp_q.push_back(mk_frame(L1, 2'b00, 21'd0));
        strobe_loc(L1);
        wait_busy("evt_first_start", 50);
        repeat (100) @(negedge clk);
        location_in       = L2;
        location_in_valid = 1'b1;
        event_in          = EV;
        event_valid_in    = 1'b1;
        exp_q.push_back(mk_frame(L2, 2'b01, EV));
        @(negedge clk);
        location_in_valid = 1'b0;
        event_valid_in    = 1'b0;
        check("ready_after_accept", 128'(event_ready_out), 128'd0);
        wait_done("evt_prev_frame", 2000);
        check("ready_while_pending", 128'(event_ready_out), 128'd0);
        @(negedge clk);
        check("evt_start_cycle_ready", 128'(event_ready_out), 128'd0);
        @(negedge clk);
        check("evt_frame_busy", 128'(busy_out), 128'd1);
        check("ready_after_load", 128'(event_ready_out), 128'd1);
        wait_done("evt_frame", 2000);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy_out) cnt++;
        end
        check("no_loc_after_evt", 128'(cnt), 128'd0);

        // Coalescing, plus an update on the start cycle itself
        exp_q.push_back(mk_frame(LA, 2'b00, 21'd0));
        strobe_loc(LA);
        wait_busy("coal_start", 50);
        repeat (50) @(negedge clk);
        strobe_loc(L1);
        repeat (5) @(negedge clk);
        strobe_loc(L2);
        exp_q.push_back(mk_frame(L2, 2'b00, 21'd0));
        exp_q.push_back(mk_frame(L3, 2'b00, 21'd0));
        wait_done("coal_first", 2000);
        @(negedge clk);
        check("coal_start_cycle_idle", 128'(busy_out), 128'd0);
        strobe_loc(L3);
        check("coal_second_started", 128'(busy_out), 128'd1);
        wait_done("coal_second", 2000);
        wait_done("coal_third", 2000);

        // Mid-frame reset at bit 40: this frame is never expected to complete
        strobe_loc(LR);
        begin
            bit reached = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (mon_bits >= 40) begin
                    reached = 1'b1;
                    break;
                end
            end
            if (!reached) check("timeout_bit40", 128'd0, 128'd1);
        end
        rst_in = 1'b1;
        @(negedge clk);
        check("mid_rst_sel", 128'(sel_out), 128'd1);
        check("mid_rst_busy", 128'(busy_out), 128'd0);
        check("mid_rst_ready", 128'(event_ready_out), 128'd1);
        check("mid_rst_done", 128'(frame_done_out), 128'd0);
        @(negedge clk);
        rst_in = 1'b0;
        cnt = 0;
        repeat (800) begin
            @(negedge clk);
            if (busy_out || frame_done_out) cnt++;
        end
        check("no_frame_after_rst", 128'(cnt), 128'd0);

`ifdef LINK_HEARTBEAT_EN
        exp_q.push_back(mk_frame(LH, 2'b00, 21'd0));
        exp_q.push_back(mk_frame(LH, 2'b10, 21'd0));
        exp_q.push_back(mk_frame(LH, 2'b10, 21'd0));
        strobe_loc(LH);
        wait_done("hb_loc_frame", 2000);
        for (int k = 0; k < 2; k++) begin
            cnt = 0;
            for (int i = 0; i < 5000; i++) begin
                @(negedge clk);
                cnt++;
                if (!sel_out) break;
            end
            check("hb_gap", 128'(cnt), 128'(HB + 1));
            wait_done("hb_frame", 2000);
        end
`else
        cnt = 0;
        repeat (10000) begin
            @(negedge clk);
            if (!sel_out) cnt++;
        end
        check("silent_idle", 128'(cnt), 128'd0);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
